// File: rtl/airi5c_hasti_arbiter2_pkg.sv
// airi5c_hasti_arbiter2_pkg: HASTI widths, transfer/response codes and arbiter owner encoding
package airi5c_hasti_arbiter2_pkg;
    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;
    localparam logic HASTI_RESP_OKAY  = 1'b0;
    localparam logic HASTI_RESP_ERROR = 1'b1;
    localparam logic [1:0] HASTI_ARB_OWNER_NONE = 2'd0;
    localparam logic [1:0] HASTI_ARB_OWNER_M0   = 2'd1;
    localparam logic [1:0] HASTI_ARB_OWNER_M1   = 2'd2;
    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0]  haddr;
        logic                         hwrite;
        logic [HASTI_SIZE_WIDTH-1:0]  hsize;
        logic [HASTI_BURST_WIDTH-1:0] hburst;
        logic [HASTI_PROT_WIDTH-1:0]  hprot;
        logic                         hmastlock;
        logic [HASTI_TRANS_WIDTH-1:0] htrans;
    } hasti_aph_t;
    localparam int HASTI_APH_WIDTH = $bits(hasti_aph_t);
    function automatic logic hasti_active(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
        return htrans == HASTI_TRANS_NONSEQ || htrans == HASTI_TRANS_SEQ;
    endfunction
endpackage

// File: rtl/airi5c_hasti_arb_pend_buf.sv
// airi5c_hasti_arb_pend_buf: one-entry address-phase buffer; output selects buffered or live request
module airi5c_hasti_arb_pend_buf
    import airi5c_hasti_arbiter2_pkg::*;
(
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic                       load,
    input  logic                       clear,
    input  logic [HASTI_APH_WIDTH-1:0] live,
    output logic                       valid,
    output logic [HASTI_APH_WIDTH-1:0] sel
);
    logic [HASTI_APH_WIDTH-1:0] pend;

    always_ff @(posedge hclk) begin
        if (hreset)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (clear)
            valid <= 1'b0;
    end

    always_ff @(posedge hclk) begin
        if (load)
            pend <= live;
    end

    assign sel = valid ? pend : live;
endmodule

// File: rtl/airi5c_hasti_arbiter2.sv
// airi5c_hasti_arbiter2: two-master HASTI arbiter with buffered losers; AIRI5C_HASTI_ARB_FIXED_PRIO_EN gives m0 fixed tie priority
module airi5c_hasti_arbiter2
    import airi5c_hasti_arbiter2_pkg::*;
#(
    parameter int NMASTERS         = 2,
    parameter int RESET_LAST_GRANT = 1
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
    input  logic                         m0_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
    input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
    input  logic                         m0_hmastlock,
    input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
    output logic                         m0_hready,
    output logic                         m0_hresp,
    input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
    input  logic                         m1_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
    input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
    input  logic                         m1_hmastlock,
    input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
    output logic                         m1_hready,
    output logic                         m1_hresp,
    output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
    output logic                         s_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
    output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
    output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
    output logic                         s_hmastlock,
    output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
    input  logic                         s_hready,
    input  logic                         s_hresp
);
    generate
        if (NMASTERS != 2) begin : g_bad_nmasters
            $error("airi5c_hasti_arbiter2 supports exactly two masters");
        end
    endgenerate

    hasti_aph_t m0_live, m1_live, m0_src, m1_src, win;
    logic [1:0] pend_valid, live_req, req, load, clear;
    logic [1:0] data_owner, lock_owner, winner;
    logic       last_grant, tie_m0;

    assign m0_live = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock, m0_htrans};
    assign m1_live = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock, m1_htrans};

    airi5c_hasti_arb_pend_buf u_pend0 (
        .hclk  (hclk),
        .hreset(hreset),
        .load  (load[0]),
        .clear (clear[0]),
        .live  (m0_live),
        .valid (pend_valid[0]),
        .sel   (m0_src)
    );

    airi5c_hasti_arb_pend_buf u_pend1 (
        .hclk  (hclk),
        .hreset(hreset),
        .load  (load[1]),
        .clear (clear[1]),
        .live  (m1_live),
        .valid (pend_valid[1]),
        .sel   (m1_src)
    );

    assign m0_hready = data_owner == HASTI_ARB_OWNER_M0 ? s_hready : !pend_valid[0];
    assign m1_hready = data_owner == HASTI_ARB_OWNER_M1 ? s_hready : !pend_valid[1];
    assign m0_hresp  = data_owner == HASTI_ARB_OWNER_M0 ? s_hresp : HASTI_RESP_OKAY;
    assign m1_hresp  = data_owner == HASTI_ARB_OWNER_M1 ? s_hresp : HASTI_RESP_OKAY;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // A live request only counts while the master sees hready; otherwise it is held, not new.
    assign live_req = {hasti_active(m1_htrans) && m1_hready, hasti_active(m0_htrans) && m0_hready};
    assign req      = pend_valid | live_req;

`ifdef AIRI5C_HASTI_ARB_FIXED_PRIO_EN
    assign tie_m0 = 1'b1;
`else
    assign tie_m0 = last_grant;
`endif

    always_comb begin
        winner = !s_hready                                   ? HASTI_ARB_OWNER_NONE :
                 lock_owner == HASTI_ARB_OWNER_M0 && req[0]  ? HASTI_ARB_OWNER_M0 :
                 lock_owner == HASTI_ARB_OWNER_M1 && req[1]  ? HASTI_ARB_OWNER_M1 :
                 req[0] && (!req[1] || tie_m0)               ? HASTI_ARB_OWNER_M0 :
                 req[1]                                      ? HASTI_ARB_OWNER_M1 :
                                                               HASTI_ARB_OWNER_NONE;
        win = winner == HASTI_ARB_OWNER_M1 ? m1_src : m0_src;
    end

    assign load[0]  = s_hready && live_req[0] && winner != HASTI_ARB_OWNER_M0;
    assign load[1]  = s_hready && live_req[1] && winner != HASTI_ARB_OWNER_M1;
    assign clear[0] = pend_valid[0] && winner == HASTI_ARB_OWNER_M0;
    assign clear[1] = pend_valid[1] && winner == HASTI_ARB_OWNER_M1;

    assign s_haddr     = win.haddr;
    assign s_hwrite    = win.hwrite;
    assign s_hsize     = win.hsize;
    assign s_hburst    = win.hburst;
    assign s_hprot     = win.hprot;
    assign s_hmastlock = win.hmastlock;
    assign s_htrans    = winner == HASTI_ARB_OWNER_NONE ? HASTI_TRANS_IDLE : win.htrans;
    assign s_hwdata    = data_owner == HASTI_ARB_OWNER_M0 ? m0_hwdata :
                         data_owner == HASTI_ARB_OWNER_M1 ? m1_hwdata : '0;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            data_owner <= HASTI_ARB_OWNER_NONE;
            lock_owner <= HASTI_ARB_OWNER_NONE;
            last_grant <= RESET_LAST_GRANT != 0;
        end else if (s_hready) begin
            data_owner <= winner;
            lock_owner <= winner != HASTI_ARB_OWNER_NONE && win.hmastlock ? winner : HASTI_ARB_OWNER_NONE;
            if (winner != HASTI_ARB_OWNER_NONE)
                last_grant <= winner == HASTI_ARB_OWNER_M1;
        end
    end
endmodule

// File: tb/tb_airi5c_hasti_arbiter2.sv
// tb_airi5c_hasti_arbiter2: directed vector table plus hand sequences for waits, lock and reset
module tb_airi5c_hasti_arbiter2;
    logic        hclk = 1'b0, hreset = 1'b1;
    logic [31:0] m0_haddr = '0, m1_haddr = '0, m0_hwdata = '0, m1_hwdata = '0;
    logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0, m0_hmastlock = 1'b0, m1_hmastlock = 1'b0;
    logic [1:0]  m0_htrans = 2'b00, m1_htrans = 2'b00;
    logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata, s_hrdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp, s_hwrite, s_hmastlock;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;
    logic        stall = 1'b0, s_hresp = 1'b0, s_hready;
    int          total = 0, bad = 0;

    always #5 hclk = ~hclk;

    airi5c_hasti_arbiter2 dut (
        .hclk(hclk), .hreset(hreset),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(3'b010), .m0_hburst(3'b000),
        .m0_hprot(4'b0011), .m0_hmastlock(m0_hmastlock), .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata),
        .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(3'b010), .m1_hburst(3'b000),
        .m1_hprot(4'b0011), .m1_hmastlock(m1_hmastlock), .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata),
        .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
    );

    // Simple SRAM slave: mem[i] starts as A500_0000+i, writes land at the end of the data phase.
    logic [31:0] mem [256];
    logic        dp_act = 1'b0, dp_wr = 1'b0, mem_ready = 1'b0;
    logic [7:0]  dp_idx = '0;
    assign s_hready = !stall;
    assign s_hrdata = mem[dp_idx];
    always @(posedge hclk) begin
        if (hreset) begin
            dp_act <= 1'b0;
            if (!mem_ready) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + i;
                mem_ready <= 1'b1;
            end
        end else if (s_hready) begin
            if (dp_act && dp_wr) mem[dp_idx] <= s_hwdata;
            dp_act <= s_htrans[1];
            dp_wr  <= s_hwrite;
            dp_idx <= s_haddr[9:2];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic l0,
                         input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic l1);
        m0_htrans = t0; m0_haddr = a0; m0_hwrite = w0; m0_hmastlock = l0;
        m1_htrans = t1; m1_haddr = a1; m1_hwrite = w1; m1_hmastlock = l1;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic [1:0]  et;
        logic [31:0] ea;
        logic        ca;
        logic        eh0;
        logic        eh1;
    } vec_t;

    localparam logic [1:0] I = 2'b00, N = 2'b10, S = 2'b11;
    vec_t v [15];

    initial begin
        v[0]  = '{N, 32'h200, N, 32'h300, N, 32'h200, 1'b1, 1'b1, 1'b1};
        v[1]  = '{I, 32'h000, N, 32'h300, N, 32'h300, 1'b1, 1'b1, 1'b0};
        v[2]  = '{I, 32'h000, I, 32'h000, I, 32'h000, 1'b0, 1'b1, 1'b1};
        v[3]  = '{N, 32'h100, I, 32'h000, N, 32'h100, 1'b1, 1'b1, 1'b1};
        v[4]  = '{I, 32'h000, I, 32'h000, I, 32'h000, 1'b0, 1'b1, 1'b1};
        v[5]  = '{I, 32'h000, N, 32'h180, N, 32'h180, 1'b1, 1'b1, 1'b1};
        v[6]  = '{I, 32'h000, I, 32'h000, I, 32'h000, 1'b0, 1'b1, 1'b1};
        v[7]  = '{N, 32'h400, N, 32'h500, N, 32'h400, 1'b1, 1'b1, 1'b1};
        v[8]  = '{N, 32'h404, N, 32'h500, N, 32'h500, 1'b1, 1'b1, 1'b0};
        v[9]  = '{N, 32'h404, N, 32'h504, N, 32'h404, 1'b1, 1'b0, 1'b1};
        v[10] = '{N, 32'h408, N, 32'h504, N, 32'h504, 1'b1, 1'b1, 1'b0};
        v[11] = '{N, 32'h408, N, 32'h508, N, 32'h408, 1'b1, 1'b0, 1'b1};
        v[12] = '{N, 32'h40C, N, 32'h508, N, 32'h508, 1'b1, 1'b1, 1'b0};
        v[13] = '{N, 32'h40C, I, 32'h000, N, 32'h40C, 1'b1, 1'b0, 1'b1};
        v[14] = '{I, 32'h000, I, 32'h000, I, 32'h000, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rst_htrans", 32'(s_htrans), 32'(I));
        chk("rst_h0", 32'(m0_hready), 1);
        chk("rst_h1", 32'(m1_hready), 1);
        chk("rst_resp", 32'({m0_hresp, m1_hresp}), 0);
        chk("rst_hwdata", s_hwdata, 0);
        step();

        for (int i = 0; i < 15; i++) begin
            drive(v[i].t0, v[i].a0, 1'b0, 1'b0, v[i].t1, v[i].a1, 1'b0, 1'b0);
            @(negedge hclk);
            chk($sformatf("v%0d_htrans", i), 32'(s_htrans), 32'(v[i].et));
            if (v[i].ca) chk($sformatf("v%0d_haddr", i), s_haddr, v[i].ea);
            chk($sformatf("v%0d_h0", i), 32'(m0_hready), 32'(v[i].eh0));
            chk($sformatf("v%0d_h1", i), 32'(m1_hready), 32'(v[i].eh1));
            step();
        end

        drive(N, 32'h100, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        step();
        drive(I, 0, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        @(negedge hclk);
        chk("rd_data", m0_hrdata, 32'hA500_0040);
        chk("rd_h0", 32'(m0_hready), 1);
        step();

        drive(I, 0, 1'b0, 1'b0, N, 32'h300, 1'b1, 1'b0);
        @(negedge hclk);
        chk("wr_hwrite", 32'(s_hwrite), 1);
        step();
        drive(I, 0, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        m1_hwdata = 32'hDEAD_BEEF;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_hresp = (k == 2);
            @(negedge hclk);
            chk($sformatf("ws%0d_hwdata", k), s_hwdata, 32'hDEAD_BEEF);
            chk($sformatf("ws%0d_h1", k), 32'(m1_hready), 0);
            chk($sformatf("ws%0d_h0", k), 32'(m0_hready), 1);
            chk($sformatf("ws%0d_htrans", k), 32'(s_htrans), 32'(I));
            if (k == 2) chk("ws_resp", 32'({m0_hresp, m1_hresp}), 32'b01);
            step();
        end
        stall = 1'b0;
        s_hresp = 1'b0;
        @(negedge hclk);
        chk("ws_end_h1", 32'(m1_hready), 1);
        step();
        @(negedge hclk);
        chk("ws_mem", mem[8'hC0], 32'hDEAD_BEEF);
        step();

        drive(I, 0, 1'b0, 1'b0, N, 32'h600, 1'b0, 1'b1);
        @(negedge hclk);
        chk("lk0_haddr", s_haddr, 32'h600);
        chk("lk0_lock", 32'(s_hmastlock), 1);
        step();
        drive(N, 32'h700, 1'b0, 1'b0, S, 32'h604, 1'b0, 1'b1);
        @(negedge hclk);
        chk("lk1_haddr", s_haddr, 32'h604);
        chk("lk1_h0", 32'(m0_hready), 1);
        step();
        drive(N, 32'h700, 1'b0, 1'b0, S, 32'h608, 1'b0, 1'b1);
        @(negedge hclk);
        chk("lk2_haddr", s_haddr, 32'h608);
        chk("lk2_h0", 32'(m0_hready), 0);
        step();
        drive(N, 32'h700, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        @(negedge hclk);
        chk("lk3_haddr", s_haddr, 32'h700);
        chk("lk3_htrans", 32'(s_htrans), 32'(N));
        chk("lk3_h0", 32'(m0_hready), 0);
        step();
        drive(I, 0, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        @(negedge hclk);
        chk("lk4_h0", 32'(m0_hready), 1);
        chk("lk4_htrans", 32'(s_htrans), 32'(I));
        step();

        drive(N, 32'h340, 1'b0, 1'b0, N, 32'h240, 1'b1, 1'b0);
        @(negedge hclk);
        chk("rs0_haddr", s_haddr, 32'h240);
        step();
        drive(I, 0, 1'b0, 1'b0, I, 0, 1'b0, 1'b0);
        m1_hwdata = 32'h1234_5678;
        hreset = 1'b1;
        @(negedge hclk);
        chk("rs1_h0_pend", 32'(m0_hready), 0);
        step();
        hreset = 1'b0;
        @(negedge hclk);
        chk("rs2_htrans", 32'(s_htrans), 32'(I));
        chk("rs2_h0", 32'(m0_hready), 1);
        chk("rs2_h1", 32'(m1_hready), 1);
        chk("rs2_hwdata", s_hwdata, 0);
        step();
        @(negedge hclk);
        chk("rs3_htrans", 32'(s_htrans), 32'(I));
        chk("rs3_mem", mem[8'h90], 32'hA500_0090);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
